data_memory_target: RTL and testbench

//  Responder end of the core's data bus: decodes bus_address/enables/byte lanes driven by the
//  CPU-side memory interface and serves them from a word-wide on-chip RAM.

---
 rtl/data_memory_pkg.sv | 24 ++
 rtl/data_memory_write_buffer.sv | 38 +++
 rtl/data_memory_target.sv | 71 +++++++
 tb/tb_data_memory_target.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the data-memory responder and its write buffer.
package data_memory_pkg;

  localparam int WORD_BYTES = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] index;
    logic [31:0] data;
    logic [3:0]  be;
  } wb_entry_t;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] w;
    w = old_word;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (be[i]) w[8*i +: 8] = new_word[8*i +: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/data_memory_write_buffer.sv
// One-entry posted write buffer: captures an accepted write, exposes it for draining
// into the array on the next edge, and forwards its lanes to a matching read.
module data_memory_write_buffer
  import data_memory_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        capture,
  input  logic [31:0] capture_index,
  input  logic [31:0] capture_data,
  input  logic [3:0]  capture_be,
  input  logic [31:0] lookup_index,
  output wb_entry_t   entry,
  output logic [3:0]  forward_mask,
  output logic [31:0] forward_data
);

  wb_entry_t wb;

  // A new capture overwrites the entry on the same edge it drains, so it never overflows.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb <= '0;
    end else if (capture) begin
      wb.valid <= 1'b1;
      wb.index <= capture_index;
      wb.data  <= capture_data;
      wb.be    <= capture_be;
    end else begin
      wb.valid <= 1'b0;
    end
  end

  assign entry        = wb;
  assign forward_mask = (wb.valid && (wb.index == lookup_index)) ? wb.be : 4'b0000;
  assign forward_data = wb.data;

endmodule

// File: rtl/data_memory_target.sv
// Data-bus responder: word RAM behind a one-entry posted write buffer with read forwarding.
// Optional address range checking is enabled by defining DATA_MEMORY_TARGET_RANGE_CHECK_EN.
module data_memory_target
  import data_memory_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDRESS = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bus_address,
  input  logic        bus_read_enable,
  input  logic        bus_write_enable,
  input  logic [31:0] bus_write_data,
  input  logic [3:0]  bus_byte_enable,
  output logic [31:0] bus_read_data,
  output logic        bus_fault
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [IDX_W-1:0] idx;
  logic [31:0]      idx_ext;
  logic             access_fault;
  logic             accept;
  wb_entry_t        drain;
  logic [3:0]       fwd_mask;
  logic [31:0]      fwd_data;
  logic [31:0]      ram [DEPTH_WORDS];

  assign idx     = IDX_W'((bus_address - BASE_ADDRESS) >> 2);
  assign idx_ext = 32'(idx);

`ifdef DATA_MEMORY_TARGET_RANGE_CHECK_EN
  // 33-bit compare so BASE_ADDRESS + size cannot wrap past 2^32.
  logic out_of_range;
  assign out_of_range = ({1'b0, bus_address} < {1'b0, BASE_ADDRESS}) ||
                        ({1'b0, bus_address} >= ({1'b0, BASE_ADDRESS} +
                                                 33'(WORD_BYTES * DEPTH_WORDS)));
  assign access_fault = (bus_read_enable || bus_write_enable) && out_of_range;
`else
  assign access_fault = 1'b0;
`endif

  assign bus_fault = access_fault && !reset;
  assign accept    = bus_write_enable && (bus_byte_enable != 4'b0000) && !access_fault;

  data_memory_write_buffer u_write_buffer (
    .clock         (clock),
    .reset         (reset),
    .capture       (accept),
    .capture_index (idx_ext),
    .capture_data  (bus_write_data),
    .capture_be    (bus_byte_enable),
    .lookup_index  (idx_ext),
    .entry         (drain),
    .forward_mask  (fwd_mask),
    .forward_data  (fwd_data)
  );

  // Array contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (drain.valid) begin
      ram[IDX_W'(drain.index)] <= merge_lanes(ram[IDX_W'(drain.index)], drain.data, drain.be);
    end
  end

  assign bus_read_data = (bus_read_enable && !access_fault)
                         ? merge_lanes(ram[idx], fwd_data, fwd_mask) : 32'h0;

endmodule

// File: tb/tb_data_memory_target.sv
// Directed bench for data_memory_target: forwarding, lane merge, ordering, reset, range handling.
module tb_data_memory_target;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] bus_address;
  logic        bus_read_enable;
  logic        bus_write_enable;
  logic [31:0] bus_write_data;
  logic [3:0]  bus_byte_enable;
  logic [31:0] bus_read_data;
  logic        bus_fault;

  int vectors = 0;
  int miscompares = 0;

  data_memory_target #(.DEPTH_WORDS(DEPTH), .BASE_ADDRESS(BASE)) dut (
    .clock            (clock),
    .reset            (reset),
    .bus_address      (bus_address),
    .bus_read_enable  (bus_read_enable),
    .bus_write_enable (bus_write_enable),
    .bus_write_data   (bus_write_data),
    .bus_byte_enable  (bus_byte_enable),
    .bus_read_data    (bus_read_data),
    .bus_fault        (bus_fault)
  );

  always #5 clock = ~clock;

  task automatic check32(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check1(input string tag, input logic observed, input logic expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // One bus cycle: drive at the falling edge, let combinational outputs settle.
  task automatic apply(input logic re, input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be);
    @(negedge clock);
    bus_read_enable  = re;
    bus_write_enable = we;
    bus_address      = addr;
    bus_write_data   = data;
    bus_byte_enable  = be;
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, BASE, 32'h0, 4'h0);
  endtask

  initial begin
    reset            = 1'b1;
    bus_read_enable  = 1'b0;
    bus_write_enable = 1'b0;
    bus_address      = BASE;
    bus_write_data   = 32'h0;
    bus_byte_enable  = 4'h0;
    repeat (2) @(negedge clock);
    #1;
    check32("reset_rdata", bus_read_data, 32'h0);
    check1("reset_fault", bus_fault, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    // Full-word write, forwarded next cycle, then from the array.
    apply(1'b0, 1'b1, BASE + 32'd8, 32'hAABBCCDD, 4'b1111);
    apply(1'b1, 1'b0, BASE + 32'd8, 32'h0, 4'h0);
    check32("fwd_full", bus_read_data, 32'hAABBCCDD);
    idle();
    check32("rd_disabled_zero", bus_read_data, 32'h0);
    apply(1'b1, 1'b0, BASE + 32'd8, 32'h0, 4'h0);
    check32("array_full", bus_read_data, 32'hAABBCCDD);

    // Single-lane write merged with array contents.
    apply(1'b0, 1'b1, BASE + 32'd12, 32'h11223344, 4'b1111);
    idle();
    apply(1'b0, 1'b1, BASE + 32'd12, 32'h00EE0000, 4'b0100);
    apply(1'b1, 1'b0, BASE + 32'd12, 32'h0, 4'h0);
    check32("fwd_lane_merge", bus_read_data, 32'h11EE3344);
    idle();
    apply(1'b1, 1'b0, BASE + 32'd12, 32'h0, 4'h0);
    check32("array_lane_merge", bus_read_data, 32'h11EE3344);

    // Same-cycle read and write return the old word.
    apply(1'b0, 1'b1, BASE, 32'h0, 4'b1111);
    idle();
    apply(1'b1, 1'b1, BASE, 32'h5, 4'b1111);
    check32("same_cycle_old", bus_read_data, 32'h0);
    apply(1'b1, 1'b0, BASE, 32'h0, 4'h0);
    check32("same_cycle_new", bus_read_data, 32'h5);

    // Back-to-back writes: drain of the first overlaps capture of the second.
    apply(1'b0, 1'b1, BASE + 32'd4, 32'h01010101, 4'b1111);
    apply(1'b0, 1'b1, BASE + 32'd8, 32'h02020202, 4'b1111);
    apply(1'b1, 1'b0, BASE + 32'd4, 32'h0, 4'h0);
    check32("b2b_first", bus_read_data, 32'h01010101);
    apply(1'b1, 1'b0, BASE + 32'd8, 32'h0, 4'h0);
    check32("b2b_second", bus_read_data, 32'h02020202);

    // Zero byte-enable write is a no-op.
    apply(1'b0, 1'b1, BASE + 32'd4, 32'hFFFFFFFF, 4'b0000);
    apply(1'b1, 1'b0, BASE + 32'd4, 32'h0, 4'h0);
    check32("be_zero_noop", bus_read_data, 32'h01010101);

    // One word past the end: faults and drops, or aliases onto index 0.
    apply(1'b0, 1'b1, BASE + 32'(4 * DEPTH), 32'hDEADBEEF, 4'b1111);
`ifdef DATA_MEMORY_TARGET_RANGE_CHECK_EN
    check1("oor_write_fault", bus_fault, 1'b1);
`else
    check1("oor_write_fault", bus_fault, 1'b0);
`endif
    idle();
    idle();
    apply(1'b1, 1'b0, BASE, 32'h0, 4'h0);
    check1("inrange_fault", bus_fault, 1'b0);
`ifdef DATA_MEMORY_TARGET_RANGE_CHECK_EN
    check32("oor_idx0", bus_read_data, 32'h5);
`else
    check32("oor_idx0", bus_read_data, 32'hDEADBEEF);
`endif
    apply(1'b1, 1'b0, BASE - 32'd4, 32'h0, 4'h0);
`ifdef DATA_MEMORY_TARGET_RANGE_CHECK_EN
    check1("below_base_fault", bus_fault, 1'b1);
    check32("below_base_rdata", bus_read_data, 32'h0);
`else
    check1("below_base_fault", bus_fault, 1'b0);
`endif

    // Reset while a buffered write is pending discards it.
    apply(1'b0, 1'b1, BASE + 32'd20, 32'hCAFEF00D, 4'b1111);
    idle();
    idle();
    apply(1'b0, 1'b1, BASE + 32'd20, 32'h12345678, 4'b1111);
    @(negedge clock);
    bus_write_enable = 1'b0;
    bus_read_enable  = 1'b1;
    #1;
    check32("pre_reset_fwd", bus_read_data, 32'h12345678);
    reset = 1'b1;
    #1;
    check32("reset_drops_fwd", bus_read_data, 32'hCAFEF00D);
    @(negedge clock);
    reset = 1'b0;
    idle();
    apply(1'b1, 1'b0, BASE + 32'd20, 32'h0, 4'h0);
    check32("reset_array_kept", bus_read_data, 32'hCAFEF00D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
